// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port, merging pipeline results with FIFO-buffered MDU results.
// Optional feature: define WB_MDU_BYPASS_EN to let an MDU result skip the empty FIFO and write with latency 1.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_dest,
  input  logic [31:0]              pipe_data,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_dest,
  input  logic [31:0]              mdu_data,
  output logic                     rf_load,
  output logic [4:0]               rf_dest,
  output logic [31:0]              rf_in,
  input  logic [4:0]               q_a,
  input  logic [4:0]               q_b,
  input  logic [4:0]               q_d,
  output logic                     pend_a,
  output logic                     pend_b,
  output logic                     pend_d,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  LIMIT    = 8'(STARVE_LIMIT);

  logic [4:0]       dest_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [7:0]       wait_q, wait_d;
  logic             stall_q, stall_d;
  logic             rf_load_q, rf_load_d;
  logic [4:0]       rf_dest_q, rf_dest_d;
  logic [31:0]      rf_in_q, rf_in_d;
  logic             fifo_empty, mdu_hs, pipe_wr, pop, push, bypass;
  logic [DEPTH-1:0] hit_a, hit_b, hit_d;

  assign fifo_empty = (count_q == '0);
  assign mdu_ready  = rst_n && (count_q < FULL_CNT);
  assign mdu_hs     = mdu_valid && mdu_ready;
  assign pipe_wr    = pipe_valid && !stall_q && (pipe_dest != '0);
  // A forced drain always pops: the head was not popped on the cycle that armed the stall.
  assign pop        = !fifo_empty && (stall_q || !pipe_wr);
`ifdef WB_MDU_BYPASS_EN
  assign bypass     = mdu_hs && fifo_empty && !pipe_wr && !stall_q && (mdu_dest != '0);
`else
  assign bypass     = 1'b0;
`endif
  assign push       = mdu_hs && (mdu_dest != '0) && !bypass;

  always_comb begin
    rf_load_d = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_in_d   = rf_in_q;
    if (pipe_wr) begin
      rf_load_d = 1'b1;
      rf_dest_d = pipe_dest;
      rf_in_d   = pipe_data;
    end else if (pop) begin
      rf_load_d = 1'b1;
      rf_dest_d = dest_mem[rd_ptr_q];
      rf_in_d   = data_mem[rd_ptr_q];
    end else if (bypass) begin
      rf_load_d = 1'b1;
      rf_dest_d = mdu_dest;
      rf_in_d   = mdu_data;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    vld_d    = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    wait_d   = (fifo_empty || pop) ? 8'd0 : wait_q + 8'd1;
    stall_d  = !stall_q && (wait_d == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      stall_q   <= 1'b0;
      rf_load_q <= 1'b0;
      rf_dest_q <= '0;
      rf_in_q   <= '0;
    end else begin
      vld_q     <= vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      rf_load_q <= rf_load_d;
      rf_dest_q <= rf_dest_d;
      rf_in_q   <= rf_in_d;
    end
  end

  // Payload storage needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_q] <= mdu_dest;
      data_mem[wr_ptr_q] <= mdu_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    assign hit_a[gi] = vld_q[gi] && (dest_mem[gi] == q_a);
    assign hit_b[gi] = vld_q[gi] && (dest_mem[gi] == q_b);
    assign hit_d[gi] = vld_q[gi] && (dest_mem[gi] == q_d);
  end

  assign pend_a     = (q_a != '0) && (|hit_a);
  assign pend_b     = (q_b != '0) && (|hit_b);
  assign pend_d     = (q_d != '0) && (|hit_d);
  assign pipe_stall = stall_q;
  assign rf_load    = rf_load_q;
  assign rf_dest    = rf_dest_q;
  assign rf_in      = rf_in_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based model predicts every register-file write, a monitor checks them.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk, rst_n;
  logic        pipe_valid, pipe_stall, mdu_valid, mdu_ready, rf_load;
  logic [4:0]  pipe_dest, mdu_dest, rf_dest, q_a, q_b, q_d;
  logic [31:0] pipe_data, mdu_data, rf_in;
  logic        pend_a, pend_b, pend_d;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct packed { logic [4:0] dest; logic [31:0] data; } ent_t;
  typedef struct packed { logic [4:0] dest; logic [31:0] data; logic [31:0] due; } exp_t;

  ent_t mq[$];
  exp_t exq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   model_on = 0;
  int   wait_m = 0;
  bit   stall_m = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_dest(pipe_dest), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
    .q_a(q_a), .q_b(q_b), .q_d(q_d),
    .pend_a(pend_a), .pend_b(pend_b), .pend_d(pend_d),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pend_of(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].dest == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t mk(input logic [4:0] d, input logic [31:0] v, input int due);
    exp_t x;
    x.dest = d;
    x.data = v;
    x.due  = 32'(due);
    return x;
  endfunction

  // Reference model: evaluated mid-cycle on stable inputs, decides this cycle's winner.
  always @(negedge clk) begin
    bit   ready_m, pwr, had, popped, byp;
    ent_t e;
    if (model_on) begin
      ready_m = (mq.size() < DEPTH);
      check("pipe_stall", 32'(pipe_stall), 32'(stall_m));
      check("mdu_ready", 32'(mdu_ready), 32'(ready_m));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("pend_a", 32'(pend_a), 32'(pend_of(q_a)));
      check("pend_b", 32'(pend_b), 32'(pend_of(q_b)));
      check("pend_d", 32'(pend_d), 32'(pend_of(q_d)));
      pwr    = pipe_valid && !stall_m && (pipe_dest != 5'd0);
      had    = (mq.size() != 0);
      popped = 1'b0;
      byp    = 1'b0;
      if (pwr) begin
        exq.push_back(mk(pipe_dest, pipe_data, cyc + 1));
      end else if (had) begin
        e = mq.pop_front();
        exq.push_back(mk(e.dest, e.data, cyc + 1));
        popped = 1'b1;
      end
`ifdef WB_MDU_BYPASS_EN
      else if (mdu_valid && ready_m && (mdu_dest != 5'd0) && !stall_m) begin
        exq.push_back(mk(mdu_dest, mdu_data, cyc + 1));
        byp = 1'b1;
      end
`endif
      if (mdu_valid && ready_m && (mdu_dest != 5'd0) && !byp) begin
        e.dest = mdu_dest;
        e.data = mdu_data;
        mq.push_back(e);
      end
      if (had && !popped) wait_m++;
      else wait_m = 0;
      stall_m = !stall_m && (wait_m == LIMIT);
    end
  end

  // Monitor: every register-file write must match the oldest expected write, on its due cycle.
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (rf_load === 1'b1) begin
      if (exq.size() == 0) begin
        check("unexpected_write", 32'(rf_dest), 32'd0);
        if (rf_dest == 5'd0) check("unexpected_write_flag", 32'd1, 32'd0);
      end else begin
        x = exq.pop_front();
        check("rf_dest", 32'(rf_dest), 32'(x.dest));
        check("rf_in", rf_in, x.data);
        check("write_cycle", 32'(cyc), x.due);
      end
    end else if (exq.size() != 0 && int'(exq[0].due) <= cyc) begin
      x = exq.pop_front();
      check("missing_write", 32'(rf_load), 32'd1);
    end
  end

  task automatic drive(input bit pv, input logic [4:0] pd, input logic [31:0] pdat,
                       input bit mv, input logic [4:0] md, input logic [31:0] mdat,
                       input logic [4:0] qa, input logic [4:0] qb, input logic [4:0] qd);
    @(posedge clk);
    #1;
    pipe_valid = pv; pipe_dest = pd; pipe_data = pdat;
    mdu_valid  = mv; mdu_dest  = md; mdu_data  = mdat;
    q_a = qa; q_b = qb; q_d = qd;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    check("rst_rf_load", 32'(rf_load), 32'd0);
    check("rst_rf_dest", 32'(rf_dest), 32'd0);
    check("rst_rf_in", rf_in, 32'd0);
    check("rst_mdu_ready", 32'(mdu_ready), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check("rst_pend", {29'd0, pend_a, pend_b, pend_d}, 32'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_on = 1'b0;
    mq.delete();
    exq.delete();
    wait_m = 0;
    stall_m = 1'b0;
    reset_checks();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_on = 1'b1;
  endtask

  function automatic logic [4:0] rnd_dest();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    int pct;
    rst_n = 1'b0;
    pipe_valid = 1'b1; pipe_dest = 5'd5; pipe_data = 32'h5555_0005;
    mdu_valid = 1'b0; mdu_dest = 5'd0; mdu_data = 32'd0;
    q_a = 5'd5; q_b = 5'd0; q_d = 5'd5;
    repeat (3) @(posedge clk);
    reset_checks();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_on = 1'b1;

    drive(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd0);
    drive(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    // Fill the FIFO behind a busy pipeline, try a push while full, then let it drain.
    drive(1, 5'd1, 32'hA1, 1, 5'd7, 32'h11, 5'd7, 5'd8, 5'd7);
    drive(1, 5'd2, 32'hA2, 1, 5'd8, 32'h22, 5'd7, 5'd8, 5'd8);
    drive(1, 5'd3, 32'hA3, 1, 5'd9, 32'h33, 5'd7, 5'd8, 5'd9);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd8, 5'd0);
    repeat (3) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd8, 5'd0);
    // Starvation: one buffered result against a pipeline that never idles.
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 5'd9, 5'd0, 5'd9);
    for (int i = 0; i < 10; i++) drive(1, 5'(10 + i), 32'(i), 0, 5'd0, 32'd0, 5'd9, 5'd0, 5'd9);
    // Two buffered writes to the same register keep pend high until the second pop.
    drive(1, 5'd1, 32'hB1, 1, 5'd12, 32'hC1, 5'd12, 5'd0, 5'd12);
    drive(1, 5'd2, 32'hB2, 1, 5'd12, 32'hC2, 5'd12, 5'd0, 5'd12);
    repeat (4) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd12, 5'd0, 5'd12);
`ifdef WB_MDU_BYPASS_EN
    drive(0, 5'd0, 32'd0, 1, 5'd4, 32'h55, 5'd4, 5'd0, 5'd4);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd4, 5'd0, 5'd4);
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) pct = (i % 1500 == 0) ? 90 : ((i % 1000 == 0) ? 20 : 55);
      if (i == 1500) mid_reset();
      drive($urandom_range(0, 99) < pct, rnd_dest(), $urandom(),
            $urandom_range(0, 1) == 1, rnd_dest(), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    repeat (12) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("drained_expected", 32'(exq.size()), 32'd0);
    check("drained_fifo", 32'(fifo_count), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
